// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg
//   Shared pipeline definitions used by the fetch stage and its neighbours:
//   staller control codes and the all-zero word used for empty stage outputs.
package if_fetch_pkg;

  // Staller codes carried on stl_i.
  localparam logic [1:0] STL_NORMAL = 2'b00;
  localparam logic [1:0] STL_STALL  = 2'b01;
  localparam logic [1:0] STL_BUBBLE = 2'b10;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/if_fetch.sv
// if_fetch
//   Instruction fetch stage. Assembles a 32-bit little-endian instruction from
//   four single-byte reads on a byte-wide memory port, presents it to IF/ID
//   together with its PC, and handles redirects from EX, including waiting out
//   a read that was already in flight when the redirect arrived.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   stl_i           staller code (NORMAL / STALL / BUBBLE)
//   br_i, br_addr_i redirect pulse and target (low two bits ignored)
//   mem_req_o       byte-read request, mem_addr_o its byte address
//   mem_done_i      read complete, byte valid on mem_data_i
//   inst_o, pc_o    fetched instruction and its PC (zero while not ready)
//   stallreq_o      freeze request while no instruction is ready
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  stl_i,
  input  logic        br_i,
  input  logic [31:0] br_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_done_i,
  input  logic [7:0]  mem_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        stallreq_o
);

  // state   | meaning
  // S_FETCH | reading the four bytes of the word at pc
  // S_READY | assembled word held on inst_o / pc_o
  // S_DRAIN | redirect taken mid-read; waiting for the abandoned byte
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_READY = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic        gap_q;

  logic [31:0] fetch_addr;
  logic [31:0] br_tgt;
  logic        unused_br_lsb;

  assign fetch_addr    = pc_q + {30'd0, cnt_q};
  assign br_tgt        = {br_addr_i[31:2], 2'b00};
  assign unused_br_lsb = ^br_addr_i[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= {RESET_PC[31:2], 2'b00};
      cnt_q        <= 2'd0;
      buf_q        <= ZERO_WORD;
      drain_addr_q <= ZERO_WORD;
      gap_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      drain_addr_q <= drain_addr_d;
      // Request is withheld for the cycle after every done so the
      // controller never sees a request re-issued in its done cycle.
      gap_q        <= mem_done_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    drain_addr_d = drain_addr_q;

    case (state_q)
      S_FETCH: begin
        if (br_i) begin
          pc_d  = br_tgt;
          cnt_d = 2'd0;
          // Only a request actually on the bus needs draining; during the
          // post-done gap nothing is outstanding.
          if (!mem_done_i && !gap_q) begin
            state_d      = S_DRAIN;
            drain_addr_d = fetch_addr;
          end
        end else if (mem_done_i) begin
          buf_d[{cnt_q, 3'b000} +: 8] = mem_data_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_READY;
          end
        end
      end
      S_READY: begin
        if (br_i) begin
          pc_d    = br_tgt;
          cnt_d   = 2'd0;
          state_d = S_FETCH;
        end else if (stl_i == STL_NORMAL) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (br_i) begin
          pc_d = br_tgt;
        end
        if (mem_done_i) begin
          cnt_d   = 2'd0;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Gating with rst keeps the request low while reset is held; it rises
  // as soon as reset is released.
  assign mem_req_o  = !rst && (state_q != S_READY) && !gap_q;
  assign mem_addr_o = (state_q == S_DRAIN) ? drain_addr_q : fetch_addr;
  assign stallreq_o = (state_q != S_READY);
  assign inst_o     = (state_q == S_READY) ? buf_q : ZERO_WORD;
  assign pc_o       = (state_q == S_READY) ? pc_q : ZERO_WORD;

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port stl_i  input  2  staller code for IF (NORMAL/STALL/BUBBLE).
REQ-005 SHALL have port br_i  input  1  single-cycle redirect pulse from EX.
REQ-006 SHALL have port br_addr_i  input  32  redirect target.
REQ-007 SHALL have port mem_req_o  output  1  byte-read request to the memory controller.
REQ-008 SHALL have port mem_addr_o  output  32  byte address of the request.
REQ-009 SHALL have port mem_done_i  input  1  one-cycle pulse: requested byte is on mem_data_i.
REQ-010 SHALL have port mem_data_i  input  8  returned byte.
REQ-011 SHALL have port inst_o  output  32  fetched instruction to IF/ID.
REQ-012 SHALL have port pc_o  output  32  PC of inst_o to IF/ID.
REQ-013 SHALL have port stallreq_o  output  1  asks staller to freeze the pipeline while no instruction is ready.

Function
REQ-014 SHALL use three states: FETCH (reading bytes), READY (instruction held on outputs), DRAIN (waiting out one abandoned byte read).
REQ-015 SHALL keep pc (word-aligned) and a 2-bit byte counter cnt; br_addr_i[1:0] ignored (forced 0).
REQ-016 In FETCH and DRAIN, mem_req_o SHALL be 1 with mem_addr_o stable until mem_done_i; in READY mem_req_o = 0.
REQ-017 In FETCH, mem_addr_o SHALL be pc + cnt; each mem_done_i stores mem_data_i into buffer bits [8*cnt+7:8*cnt], little-endian, and increments cnt.
REQ-018 A mem_done_i with cnt = 3 in FETCH SHALL complete the word: next cycle state = READY, inst_o = assembled word, pc_o = pc, cnt = 0.
REQ-019 mem_req_o SHALL drop for at least the cycle after each mem_done_i (one request per done; no back-to-back reissue in the done cycle).
REQ-020 stallreq_o SHALL be 1 in FETCH and DRAIN, 0 in READY.
REQ-021 inst_o and pc_o SHALL be 32'h0 in FETCH and DRAIN.
REQ-022 In READY with stl_i = NORMAL and no br_i, pc SHALL advance by 4 (32-bit wrap) and state = FETCH at the next edge.
REQ-023 In READY with stl_i = STALL or BUBBLE, state, pc, inst_o and pc_o SHALL hold.
REQ-024 br_i SHALL have priority over stl_i and over completion in all states.
REQ-025 br_i in READY SHALL discard the held word, load pc = target, cnt = 0, state = FETCH.
REQ-026 br_i in FETCH coinciding with mem_done_i SHALL discard the byte, load pc = target, cnt = 0, stay FETCH.
REQ-027 br_i in FETCH without mem_done_i SHALL load pc = target, cnt = 0, state = DRAIN; old mem_addr_o held.
REQ-028 In DRAIN, mem_done_i SHALL discard data and go to FETCH; br_i in DRAIN SHALL only overwrite pc (a coincident done still exits to FETCH).
REQ-029 stl_i SHALL not affect FETCH or DRAIN progress.

Reset
REQ-030 On rst: state = FETCH, pc = RESET_PC, cnt = 0, buffer = 0, inst_o = 0, pc_o = 0; mem_req_o = 1 from the first cycle after rst deasserts.
REQ-031 rst mid-fetch SHALL abandon the outstanding read; the memory controller is reset by the same rst.

Structure
REQ-032 Staller codes (NORMAL/STALL/BUBBLE) and ZeroWord SHALL come from the shared macro header, not local literals.
REQ-033 State encodings SHALL be local to this module; no sub-module: a single module containing the FSM, the byte assembler and the PC register.

Verification
REQ-034 Reset, then bytes 13,00,00,00 at addr 0..3, stl_i = NORMAL -> inst_o = 32'h0000_0013, pc_o = 0 for one cycle, then mem_addr_o = 4.
REQ-035 READY at pc 8, stl_i = STALL for 5 cycles -> outputs held, mem_req_o = 0, then NORMAL -> fetch starts at 12.
REQ-036 br_i with target 32'h100 while cnt = 2 and no done -> DRAIN, old addr held until done, then reads 0x100..0x103.
REQ-037 br_i with target 32'h203 coinciding with done -> byte dropped, next mem_addr_o = 32'h200.
REQ-038 pc = 32'hFFFF_FFFC completes with NORMAL -> next fetch at 32'h0.
REQ-039 rst asserted during cnt = 1 -> all outputs 0 immediately, refetch from RESET_PC.
